// File: rtl/reorder_buffer_p_if.sv
// Bundle of allocation, lookup, completion and commit signals for the reorder buffer.
// The core side drives through master; the buffer itself sits on slave.
interface reorder_buffer_p_if #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = $clog2(DEPTH + 1),
  parameter int NUM_CDB = 2,
  parameter int DATA_W  = 32
);
  logic                      alloc_valid;
  logic [1:0]                alloc_kind;
  logic [4:0]                alloc_dest;
  logic [1:0]                alloc_size;
  logic [DATA_W-1:0]         alloc_pc;
  logic                      alloc_pred;
  logic [TAG_W-1:0]          alloc_tag;
  logic                      full;
  logic [TAG_W-1:0]          count;

  logic [TAG_W-1:0]          rd_tag0;
  logic [TAG_W-1:0]          rd_tag1;
  logic [DATA_W-1:0]         rd_value0;
  logic [DATA_W-1:0]         rd_value1;
  logic                      rd_ready0;
  logic                      rd_ready1;

  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_value;
  logic [NUM_CDB*DATA_W-1:0] cdb_newpc;
  logic [NUM_CDB*DATA_W-1:0] cdb_addr;

  logic [DATA_W-1:0]         lsb_addr;
  logic                      lsb_conflict;

  logic                      cm_reg_valid;
  logic [4:0]                cm_reg_idx;
  logic [TAG_W-1:0]          cm_reg_tag;
  logic [DATA_W-1:0]         cm_reg_value;

  logic                      mem_req;
  logic [1:0]                mem_size;
  logic [DATA_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;
  logic                      mem_done;

  logic                      bp_valid;
  logic [DATA_W-1:0]         bp_pc;
  logic                      bp_taken;

  logic                      flush;
  logic [DATA_W-1:0]         flush_pc;

  modport master (
    output alloc_valid, alloc_kind, alloc_dest, alloc_size, alloc_pc, alloc_pred,
    input  alloc_tag, full, count,
    output rd_tag0, rd_tag1,
    input  rd_value0, rd_value1, rd_ready0, rd_ready1,
    output cdb_tag, cdb_value, cdb_newpc, cdb_addr,
    output lsb_addr,
    input  lsb_conflict,
    input  cm_reg_valid, cm_reg_idx, cm_reg_tag, cm_reg_value,
    input  mem_req, mem_size, mem_addr, mem_data,
    output mem_done,
    input  bp_valid, bp_pc, bp_taken,
    input  flush, flush_pc
  );

  modport slave (
    input  alloc_valid, alloc_kind, alloc_dest, alloc_size, alloc_pc, alloc_pred,
    output alloc_tag, full, count,
    input  rd_tag0, rd_tag1,
    output rd_value0, rd_value1, rd_ready0, rd_ready1,
    input  cdb_tag, cdb_value, cdb_newpc, cdb_addr,
    input  lsb_addr,
    output lsb_conflict,
    output cm_reg_valid, cm_reg_idx, cm_reg_tag, cm_reg_value,
    output mem_req, mem_size, mem_addr, mem_data,
    input  mem_done,
    output bp_valid, bp_pc, bp_taken,
    output flush, flush_pc
  );
endinterface

// File: rtl/reorder_buffer_p.sv
// Reorder buffer: in-order allocation, CDB completion capture and single-entry retire
// to regfile, memory (stores, via a WAIT_MEM handshake) or branch predictor with flush.
module reorder_buffer_p #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = $clog2(DEPTH + 1),
  parameter int NUM_CDB = 2,
  parameter int DATA_W  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  reorder_buffer_p_if.slave bus
);

  typedef enum logic [1:0] {
    KIND_REG  = 2'd0,
    KIND_BR   = 2'd1,
    KIND_ST   = 2'd2,
    KIND_JALR = 2'd3
  } kind_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_MEM
  } state_e;

  typedef struct packed {
    kind_e             kind;
    logic [4:0]        dest;
    logic [1:0]        size;
    logic              pred;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] newpc;
    logic [DATA_W-1:0] addr;
  } entry_t;

  typedef struct packed {
    logic              cm_reg_valid;
    logic [4:0]        cm_reg_idx;
    logic [TAG_W-1:0]  cm_reg_tag;
    logic [DATA_W-1:0] cm_reg_value;
    logic              mem_req;
    logic [1:0]        mem_size;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              bp_valid;
    logic [DATA_W-1:0] bp_pc;
    logic              bp_taken;
    logic              flush;
    logic [DATA_W-1:0] flush_pc;
  } out_t;

  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(DEPTH);

  function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] p);
    return (p == TAG_LAST) ? TAG_ONE : p + TAG_ONE;
  endfunction

  state_e           state_q, state_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;
  logic [DEPTH:1]   valid_q, valid_d;
  logic [DEPTH:1]   ready_q, ready_d;
  logic [DEPTH:1]   addrv_q, addrv_d;
  entry_t           entry_q [1:DEPTH];
  entry_t           entry_d [1:DEPTH];
  out_t             out_q, out_d;

  logic             full;
  logic             alloc_fire;
  logic             retire;
  entry_t           head_e;
  logic             head_done;
  logic             br_taken;

  assign full       = (count_q == TAG_LAST);
  assign alloc_fire = bus.alloc_valid && !full;
  assign head_e     = entry_q[head_q];
  assign head_done  = valid_q[head_q] && ready_q[head_q];
  assign br_taken   = (head_e.value != '0);

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    valid_d  = valid_q;
    ready_d  = ready_q;
    addrv_d  = addrv_q;
    entry_d  = entry_q;
    out_d    = out_q;
    out_d.cm_reg_valid = 1'b0;
    out_d.mem_req      = 1'b0;
    out_d.bp_valid     = 1'b0;
    out_d.flush        = 1'b0;
    retire   = 1'b0;

    if (out_q.flush) begin
      // The flush cycle ignores every input and lands back in the reset state.
      state_d = ST_IDLE;
      head_d  = TAG_ONE;
      tail_d  = TAG_ONE;
      count_d = '0;
      valid_d = '0;
      ready_d = '0;
      addrv_d = '0;
      out_d   = '0;
    end else begin
      if (alloc_fire) begin
        valid_d[tail_q]       = 1'b1;
        ready_d[tail_q]       = 1'b0;
        addrv_d[tail_q]       = 1'b0;
        entry_d[tail_q].kind  = kind_e'(bus.alloc_kind);
        entry_d[tail_q].dest  = bus.alloc_dest;
        entry_d[tail_q].size  = bus.alloc_size;
        entry_d[tail_q].pc    = bus.alloc_pc;
        entry_d[tail_q].pred  = bus.alloc_pred;
        tail_d                = next_ptr(tail_q);
      end

      // Ascending bus order lets the highest-index bus win a same-tag collision.
      for (int i = 1; i <= DEPTH; i++) begin
        for (int b = 0; b < NUM_CDB; b++) begin
          if (valid_q[i] && bus.cdb_tag[b*TAG_W +: TAG_W] == TAG_W'(i)) begin
            ready_d[i]       = 1'b1;
            entry_d[i].value = bus.cdb_value[b*DATA_W +: DATA_W];
            entry_d[i].newpc = bus.cdb_newpc[b*DATA_W +: DATA_W];
            if (entry_q[i].kind == KIND_ST) begin
              entry_d[i].addr = bus.cdb_addr[b*DATA_W +: DATA_W];
              addrv_d[i]      = 1'b1;
            end
          end
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (head_done) begin
            case (head_e.kind)
              KIND_REG: begin
                out_d.cm_reg_valid = 1'b1;
                out_d.cm_reg_idx   = head_e.dest;
                out_d.cm_reg_tag   = head_q;
                out_d.cm_reg_value = head_e.value;
                retire             = 1'b1;
              end
              KIND_BR: begin
                out_d.bp_valid = 1'b1;
                out_d.bp_pc    = head_e.pc;
                out_d.bp_taken = br_taken;
                retire         = 1'b1;
                if (br_taken != head_e.pred) begin
                  out_d.flush    = 1'b1;
                  out_d.flush_pc = br_taken ? head_e.newpc : head_e.pc + DATA_W'(4);
                end
              end
              KIND_JALR: begin
                out_d.cm_reg_valid = 1'b1;
                out_d.cm_reg_idx   = head_e.dest;
                out_d.cm_reg_tag   = head_q;
                out_d.cm_reg_value = head_e.value;
                out_d.flush        = 1'b1;
                out_d.flush_pc     = head_e.newpc;
                retire             = 1'b1;
              end
              default: begin
                out_d.mem_req  = 1'b1;
                out_d.mem_size = head_e.size;
                out_d.mem_addr = head_e.addr;
                out_d.mem_data = head_e.value;
                state_d        = ST_WAIT_MEM;
              end
            endcase
          end
        end
        ST_WAIT_MEM: begin
          if (bus.mem_done) begin
            retire  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (retire) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        addrv_d[head_q] = 1'b0;
        head_d          = next_ptr(head_q);
      end

      case ({alloc_fire, retire})
        2'b10:   count_d = count_q + TAG_ONE;
        2'b01:   count_d = count_q - TAG_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      head_q  <= TAG_ONE;
      tail_q  <= TAG_ONE;
      count_q <= '0;
      valid_q <= '0;
      ready_q <= '0;
      addrv_q <= '0;
      out_q   <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      addrv_q <= addrv_d;
      out_q   <= out_d;
    end
  end

  // NOTE: the payload array is not reset; valid/ready/addr_valid gate every read of it.
  always_ff @(posedge clk) begin
    if (rdy) entry_q <= entry_d;
  end

  logic [DATA_W-1:0] rd_value0, rd_value1;
  logic              rd_ready0, rd_ready1;
  logic              lsb_conflict;

  always_comb begin
    rd_value0    = '0;
    rd_value1    = '0;
    rd_ready0    = 1'b0;
    rd_ready1    = 1'b0;
    lsb_conflict = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (valid_q[i] && bus.rd_tag0 == TAG_W'(i)) begin
        rd_value0 = entry_q[i].value;
        rd_ready0 = ready_q[i];
      end
      if (valid_q[i] && bus.rd_tag1 == TAG_W'(i)) begin
        rd_value1 = entry_q[i].value;
        rd_ready1 = ready_q[i];
      end
      if (valid_q[i] && entry_q[i].kind == KIND_ST && addrv_q[i] &&
          entry_q[i].addr == bus.lsb_addr) begin
        lsb_conflict = 1'b1;
      end
    end
  end

  assign bus.alloc_tag    = full ? '0 : tail_q;
  assign bus.full         = full;
  assign bus.count        = count_q;
  assign bus.rd_value0    = rd_value0;
  assign bus.rd_value1    = rd_value1;
  assign bus.rd_ready0    = rd_ready0;
  assign bus.rd_ready1    = rd_ready1;
  assign bus.lsb_conflict = lsb_conflict;
  assign bus.cm_reg_valid = out_q.cm_reg_valid;
  assign bus.cm_reg_idx   = out_q.cm_reg_idx;
  assign bus.cm_reg_tag   = out_q.cm_reg_tag;
  assign bus.cm_reg_value = out_q.cm_reg_value;
  assign bus.mem_req      = out_q.mem_req;
  assign bus.mem_size     = out_q.mem_size;
  assign bus.mem_addr     = out_q.mem_addr;
  assign bus.mem_data     = out_q.mem_data;
  assign bus.bp_valid     = out_q.bp_valid;
  assign bus.bp_pc        = out_q.bp_pc;
  assign bus.bp_taken     = out_q.bp_taken;
  assign bus.flush        = out_q.flush;
  assign bus.flush_pc     = out_q.flush_pc;

endmodule

// File: tb/tb_reorder_buffer_p.sv
// Directed bench for reorder_buffer_p (DEPTH=4): commit pulses are checked by a
// scoreboard monitor, occupancy/lookup/conflict outputs by inline checks.
module tb_reorder_buffer_p;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 3;
  localparam int NUM_CDB = 2;
  localparam int DATA_W  = 32;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  reorder_buffer_p_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W)) bus ();

  reorder_buffer_p #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  typedef struct packed {
    logic             cm;
    logic [4:0]       idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      val;
    logic             mem;
    logic [1:0]       size;
    logic [31:0]      maddr;
    logic [31:0]      mdata;
    logic             bp;
    logic [31:0]      bppc;
    logic             bpt;
    logic             fl;
    logic [31:0]      flpc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void push_reg(input logic [4:0] idx, input logic [TAG_W-1:0] tag,
                                   input logic [31:0] val);
    exp_t e = '0;
    e.cm = 1'b1; e.idx = idx; e.tag = tag; e.val = val;
    q.push_back(e);
  endfunction

  function automatic void push_jalr(input logic [4:0] idx, input logic [TAG_W-1:0] tag,
                                    input logic [31:0] val, input logic [31:0] flpc);
    exp_t e = '0;
    e.cm = 1'b1; e.idx = idx; e.tag = tag; e.val = val; e.fl = 1'b1; e.flpc = flpc;
    q.push_back(e);
  endfunction

  function automatic void push_mem(input logic [1:0] size, input logic [31:0] addr,
                                   input logic [31:0] data);
    exp_t e = '0;
    e.mem = 1'b1; e.size = size; e.maddr = addr; e.mdata = data;
    q.push_back(e);
  endfunction

  function automatic void push_bp(input logic [31:0] pc, input logic taken,
                                  input logic fl, input logic [31:0] flpc);
    exp_t e = '0;
    e.bp = 1'b1; e.bppc = pc; e.bpt = taken; e.fl = fl; e.flpc = flpc;
    q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Commit monitor: one comparison per enabled cycle that shows any pulse.
  exp_t mon_e;
  logic mon_en;
  logic mon_ok;
  always @(posedge clk) begin
    mon_en = rdy && !rst;
    #1;
    if (mon_en && (bus.cm_reg_valid || bus.mem_req || bus.bp_valid || bus.flush)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL commit_unexpected: got cm=%b mem=%b bp=%b fl=%b expected no pulse",
                 bus.cm_reg_valid, bus.mem_req, bus.bp_valid, bus.flush);
      end else begin
        mon_e  = q.pop_front();
        mon_ok = (bus.cm_reg_valid === mon_e.cm) && (bus.mem_req === mon_e.mem) &&
                 (bus.bp_valid === mon_e.bp) && (bus.flush === mon_e.fl) &&
                 (!mon_e.cm  || (bus.cm_reg_idx === mon_e.idx && bus.cm_reg_tag === mon_e.tag &&
                                 bus.cm_reg_value === mon_e.val)) &&
                 (!mon_e.mem || (bus.mem_size === mon_e.size && bus.mem_addr === mon_e.maddr &&
                                 bus.mem_data === mon_e.mdata)) &&
                 (!mon_e.bp  || (bus.bp_pc === mon_e.bppc && bus.bp_taken === mon_e.bpt)) &&
                 (!mon_e.fl  || (bus.flush_pc === mon_e.flpc));
        if (!mon_ok) begin
          n_bad++;
          $display("FAIL commit: got cm=%b idx=%0d tag=%0d val=%h mem=%b sz=%0d a=%h d=%h bp=%b pc=%h t=%b fl=%b fpc=%h expected cm=%b idx=%0d tag=%0d val=%h mem=%b sz=%0d a=%h d=%h bp=%b pc=%h t=%b fl=%b fpc=%h",
                   bus.cm_reg_valid, bus.cm_reg_idx, bus.cm_reg_tag, bus.cm_reg_value,
                   bus.mem_req, bus.mem_size, bus.mem_addr, bus.mem_data,
                   bus.bp_valid, bus.bp_pc, bus.bp_taken, bus.flush, bus.flush_pc,
                   mon_e.cm, mon_e.idx, mon_e.tag, mon_e.val, mon_e.mem, mon_e.size,
                   mon_e.maddr, mon_e.mdata, mon_e.bp, mon_e.bppc, mon_e.bpt, mon_e.fl, mon_e.flpc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.alloc_kind  = '0;
    bus.alloc_dest  = '0;
    bus.alloc_size  = '0;
    bus.alloc_pc    = '0;
    bus.alloc_pred  = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_value   = '0;
    bus.cdb_newpc   = '0;
    bus.cdb_addr    = '0;
    bus.mem_done    = 1'b0;
  endtask

  task automatic do_alloc(input logic [1:0] kind, input logic [4:0] dest, input logic [1:0] size,
                          input logic [31:0] pc, input logic pred);
    bus.alloc_valid = 1'b1;
    bus.alloc_kind  = kind;
    bus.alloc_dest  = dest;
    bus.alloc_size  = size;
    bus.alloc_pc    = pc;
    bus.alloc_pred  = pred;
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic set_cdb(input int b, input logic [TAG_W-1:0] tag, input logic [31:0] val,
                         input logic [31:0] newpc, input logic [31:0] addr);
    bus.cdb_tag[b*TAG_W +: TAG_W]    = tag;
    bus.cdb_value[b*DATA_W +: DATA_W] = val;
    bus.cdb_newpc[b*DATA_W +: DATA_W] = newpc;
    bus.cdb_addr[b*DATA_W +: DATA_W]  = addr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rdy = 1'b1;
    rst = 1'b1;
    idle();
    bus.rd_tag0  = '0;
    bus.rd_tag1  = '0;
    bus.lsb_addr = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset_count", 32'(bus.count), 0);
    check("reset_alloc_tag", 32'(bus.alloc_tag), 1);
    check("reset_full", 32'(bus.full), 0);
    check("reset_cm_valid", 32'(bus.cm_reg_valid), 0);
    check("reset_flush", 32'(bus.flush), 0);
    check("reset_flush_pc", bus.flush_pc, 0);

    // Fill: five allocations, fifth ignored
    for (int i = 1; i <= 5; i++) begin
      check("fill_alloc_tag", 32'(bus.alloc_tag), (i <= 4) ? 32'(i) : 32'd0);
      do_alloc(2'd0, 5'(4 + i), 2'd0, 32'h1000 + 32'(4 * i), 1'b0);
    end
    check("fill_full", 32'(bus.full), 1);
    check("fill_count", 32'(bus.count), 4);

    // Out-of-order completion 3,1 then 4,2; commits in tag order
    push_reg(5'd5, 3'd1, 32'h11);
    push_reg(5'd6, 3'd2, 32'h22);
    push_reg(5'd7, 3'd3, 32'h33);
    push_reg(5'd8, 3'd4, 32'h44);
    set_cdb(0, 3'd3, 32'h33, 0, 0);
    set_cdb(1, 3'd1, 32'h11, 0, 0);
    tick();
    idle();
    bus.rd_tag0 = 3'd3;
    bus.rd_tag1 = 3'd2;
    #1;
    check("rd_ready_tag3", 32'(bus.rd_ready0), 1);
    check("rd_value_tag3", bus.rd_value0, 32'h33);
    check("rd_ready_tag2_pending", 32'(bus.rd_ready1), 0);
    set_cdb(0, 3'd4, 32'h44, 0, 0);
    set_cdb(1, 3'd2, 32'h22, 0, 0);
    tick();
    idle();
    check("wrap_count_after_first_retire", 32'(bus.count), 3);
    repeat (4) tick();
    check("wrap_count_drained", 32'(bus.count), 0);
    check("wrap_alloc_tag", 32'(bus.alloc_tag), 1);

    // Same-tag collision on both buses: bus 1 wins
    do_alloc(2'd0, 5'd1, 2'd0, 32'h2000, 1'b0);
    do_alloc(2'd0, 5'd2, 2'd0, 32'h2004, 1'b0);
    set_cdb(0, 3'd2, 32'h11, 0, 0);
    set_cdb(1, 3'd2, 32'h22, 0, 0);
    tick();
    idle();
    bus.rd_tag0 = 3'd2;
    bus.rd_tag1 = 3'd1;
    #1;
    check("collision_value", bus.rd_value0, 32'h22);
    check("collision_ready", 32'(bus.rd_ready0), 1);
    check("collision_other_not_ready", 32'(bus.rd_ready1), 0);
    push_reg(5'd1, 3'd1, 32'h5);
    push_reg(5'd2, 3'd2, 32'h22);
    set_cdb(0, 3'd1, 32'h5, 0, 0);
    tick();
    idle();
    repeat (3) tick();
    check("collision_drained", 32'(bus.count), 0);

    // Store with delayed mem_done
    do_reset();
    check("store_alloc_tag", 32'(bus.alloc_tag), 1);
    do_alloc(2'd2, 5'd0, 2'd2, 32'h200, 1'b0);
    bus.lsb_addr = 32'h100;
    #1;
    check("lsb_conflict_before_addr", 32'(bus.lsb_conflict), 0);
    push_mem(2'd2, 32'h100, 32'hAB);
    set_cdb(0, 3'd1, 32'hAB, 0, 32'h100);
    tick();
    idle();
    check("lsb_conflict_after_addr", 32'(bus.lsb_conflict), 1);
    tick();
    check("store_no_retire", 32'(bus.count), 1);
    tick();
    check("mem_req_one_cycle", 32'(bus.mem_req), 0);
    check("store_wait_count", 32'(bus.count), 1);
    tick();
    check("lsb_conflict_waiting", 32'(bus.lsb_conflict), 1);
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    check("store_retired_count", 32'(bus.count), 0);
    check("lsb_conflict_after_retire", 32'(bus.lsb_conflict), 0);

    // Stall with rdy=0 while waiting for memory
    do_alloc(2'd2, 5'd0, 2'd0, 32'h204, 1'b0);
    push_mem(2'd0, 32'h104, 32'hCD);
    set_cdb(1, 3'd2, 32'hCD, 0, 32'h104);
    tick();
    idle();
    tick();
    rdy             = 1'b0;
    bus.mem_done    = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.lsb_addr    = 32'h104;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_count", 32'(bus.count), 1);
      check("stall_mem_req_held", 32'(bus.mem_req), 1);
      check("stall_lsb_conflict", 32'(bus.lsb_conflict), 1);
    end
    rdy             = 1'b1;
    bus.alloc_valid = 1'b0;
    tick();
    bus.mem_done = 1'b0;
    check("stall_retire_count", 32'(bus.count), 0);
    check("stall_retire_lsb", 32'(bus.lsb_conflict), 0);

    // Correctly predicted branch, then jalr flush
    do_reset();
    do_alloc(2'd1, 5'd0, 2'd0, 32'h50, 1'b1);
    do_alloc(2'd3, 5'd3, 2'd0, 32'h60, 1'b0);
    do_alloc(2'd0, 5'd9, 2'd0, 32'h64, 1'b0);
    push_bp(32'h50, 1'b1, 1'b0, 0);
    push_jalr(5'd3, 3'd2, 32'h44, 32'h300);
    set_cdb(0, 3'd1, 32'h1, 32'h90, 0);
    set_cdb(1, 3'd2, 32'h44, 32'h300, 0);
    tick();
    idle();
    tick();
    tick();
    check("jalr_flush", 32'(bus.flush), 1);
    check("jalr_flush_pc", bus.flush_pc, 32'h300);
    check("jalr_flush_count", 32'(bus.count), 1);
    tick();
    check("jalr_recover_flush", 32'(bus.flush), 0);
    check("jalr_recover_count", 32'(bus.count), 0);
    check("jalr_recover_flush_pc", bus.flush_pc, 0);

    // Mispredicted taken branch with younger entries
    do_alloc(2'd1, 5'd0, 2'd0, 32'h40, 1'b0);
    do_alloc(2'd0, 5'd4, 2'd0, 32'h44, 1'b0);
    do_alloc(2'd0, 5'd5, 2'd0, 32'h48, 1'b0);
    push_bp(32'h40, 1'b1, 1'b1, 32'h80);
    set_cdb(0, 3'd1, 32'h1, 32'h80, 0);
    tick();
    idle();
    tick();
    check("mispredict_flush", 32'(bus.flush), 1);
    check("mispredict_count_in_flush", 32'(bus.count), 2);
    bus.alloc_valid = 1'b1;
    tick();
    bus.alloc_valid = 1'b0;
    check("mispredict_recover_count", 32'(bus.count), 0);
    check("mispredict_recover_alloc_tag", 32'(bus.alloc_tag), 1);
    check("mispredict_recover_flush", 32'(bus.flush), 0);
    check("mispredict_recover_bp", 32'(bus.bp_valid), 0);

    // Mispredicted not-taken branch redirects to pc+4
    do_alloc(2'd1, 5'd0, 2'd0, 32'h70, 1'b1);
    push_bp(32'h70, 1'b0, 1'b1, 32'h74);
    set_cdb(1, 3'd1, 32'h0, 32'h500, 0);
    tick();
    idle();
    repeat (3) tick();
    check("not_taken_recover_count", 32'(bus.count), 0);

    repeat (3) tick();
    check("commit_queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
